output_axis_streamer: RTL and testbench

Downstream neighbour of the output buffer: captures the 32-bit output-feature-map words the buffer emits while its ready line is high, absorbs them in a small first-word-fall-through FIFO, and presents them to the AXI interface as an AXI4-Stream master. One frame is one complete output feature map. TLAST is asserted on the final element, and a one-cycle done pulse follows the last handshake. Words that cannot be stored are dropped and flagged rather than stalling the buffer, because the output buffer has no backpressure input.

---
 rtl/output_axis_streamer.sv | 176 +++++++++++++++++
 tb/tb_output_axis_streamer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/output_axis_streamer.sv
// output_axis_streamer
// Captures output-feature-map words from the output buffer into a small
// first-word-fall-through FIFO and presents them as an AXI4-Stream master.
// One frame is OFM_SIZE elements. TLAST marks the final element, and
// frame_done pulses the cycle after the final handshake. The upstream
// buffer cannot be stalled, so words that cannot be stored are dropped and
// flagged through a sticky overflow bit.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   in_valid       qualifies in_data (output_buffer_ready)
//   in_data        32-bit feature-map element
//   m_axis_tready  downstream ready
//   m_axis_tvalid  FIFO non-empty
//   m_axis_tdata   FIFO head word (0 while empty)
//   m_axis_tlast   high with tvalid on the frame's final element
//   frame_done     one-cycle pulse after the last handshake of a frame
//   overflow       sticky dropped-word flag, cleared only by reset
//   fill_level     FIFO occupancy
module output_axis_streamer #(
    parameter int unsigned OFM_SIZE   = 49,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CW         = $clog2(OFM_SIZE + 1),
    parameter int unsigned LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic [31:0]   m_axis_tdata,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic          overflow,
    output logic [LW-1:0] fill_level
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [CW-1:0] FRAME_LEN  = CW'(OFM_SIZE);
    localparam logic [CW-1:0] FRAME_LAST = CW'(OFM_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e         state_q,    state_d;
    logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]  in_cnt_q,   in_cnt_d;
    logic [CW-1:0]  out_cnt_q,  out_cnt_d;
    logic           tvalid_q,   tvalid_d;
    logic [DW-1:0]  tdata_q,    tdata_d;
    logic           tlast_q,    tlast_d;
    logic           done_q,     done_d;
    logic           ovf_q,      ovf_d;
    logic [LW-1:0]  fill_q,     fill_d;

    logic [DW-1:0]  mem_q [FIFO_DEPTH];

    logic           rd_en;
    logic           wr_en;
    logic           full;
    logic [CW-1:0]  in_cnt_inc;

    // Handshake and write qualification
    always_comb begin
        rd_en      = tvalid_q & m_axis_tready;
        // Same slot index with differing wrap bits means full
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_en      = in_valid && (state_q != S_DRAIN) && (!full || rd_en);
        in_cnt_inc = in_cnt_q + CW'(1);
    end

    // Pointer, output-stage and frame FSM next-state logic
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tdata_d   = '0;

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (wr_en) begin
                    in_cnt_d = in_cnt_inc;
                    state_d  = (in_cnt_inc == FRAME_LEN) ? S_DRAIN : S_RUN;
                end
                if (rd_en) out_cnt_d = out_cnt_q + CW'(1);
            end
            S_DRAIN: begin
                if (rd_en) begin
                    if (out_cnt_q == FRAME_LAST) begin
                        state_d   = S_IDLE;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
        endcase

        fill_d   = LW'(wr_ptr_d - rd_ptr_d);
        tvalid_d = (wr_ptr_d != rd_ptr_d);
        // The next head is either an existing entry or, when it lands in the
        // slot being written this cycle, the incoming word itself.
        if (tvalid_d) begin
            if (wr_en && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0]))
                tdata_d = in_data;
            else
                tdata_d = mem_q[rd_ptr_d[AW-1:0]];
        end
        tlast_d = tvalid_d && (out_cnt_d == FRAME_LAST);
        ovf_d   = ovf_q | (in_valid & ~wr_en);
    end

    // FIFO storage; contents are meaningless until the pointers cover them
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            fill_q    <= fill_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = done_q;
    assign overflow      = ovf_q;
    assign fill_level    = fill_q;

endmodule

// File: tb/tb_output_axis_streamer.sv
// Bench for output_axis_streamer: three instances (frame sizes 49, 4 and 1,
// FIFO depth 16) share one input stream and are compared every cycle with a
// queue-level reference model, plus directed checks on the key scenarios.
module tb_output_axis_streamer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        tready;

    logic [2:0]    tv;
    logic [31:0]   td [3];
    logic [2:0]    tl;
    logic [2:0]    fd;
    logic [2:0]    ovf;
    logic [LW-1:0] fill [3];

    int n_tests;
    int n_fail;

    // Reference model: per instance a word list, accepted/sent counts, flags
    int          ofm_tab [3];
    logic [31:0] mq   [3][DEPTH];
    int          mn   [3];
    int          macc [3];
    int          msent[3];
    bit          movf [3];
    bit          mdone[3];

    output_axis_streamer #(.OFM_SIZE(49), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .m_axis_tready(tready), .m_axis_tvalid(tv[0]), .m_axis_tdata(td[0]),
        .m_axis_tlast(tl[0]), .frame_done(fd[0]), .overflow(ovf[0]),
        .fill_level(fill[0]));

    output_axis_streamer #(.OFM_SIZE(4), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .m_axis_tready(tready), .m_axis_tvalid(tv[1]), .m_axis_tdata(td[1]),
        .m_axis_tlast(tl[1]), .frame_done(fd[1]), .overflow(ovf[1]),
        .fill_level(fill[1]));

    output_axis_streamer #(.OFM_SIZE(1), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .m_axis_tready(tready), .m_axis_tvalid(tv[2]), .m_axis_tdata(td[2]),
        .m_axis_tlast(tl[2]), .frame_done(fd[2]), .overflow(ovf[2]),
        .fill_level(fill[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0; macc[i] = 0; msent[i] = 0; movf[i] = 0; mdone[i] = 0;
        end
    endtask

    // One clock edge of frame-level behaviour for every instance
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit hs;
            bit wr;
            hs = (mn[i] > 0) && tready;
            wr = in_valid && (macc[i] < ofm_tab[i]) && ((mn[i] < DEPTH) || hs);
            if (in_valid && !wr) movf[i] = 1'b1;
            mdone[i] = 1'b0;
            if (hs) begin
                for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
                mn[i]--;
                msent[i]++;
                if (msent[i] == ofm_tab[i]) begin
                    msent[i] = 0; macc[i] = 0; mdone[i] = 1'b1;
                end
            end
            if (wr) begin
                mq[i][mn[i]] = in_data;
                mn[i]++;
                macc[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            bit          ev;
            logic [31:0] ed;
            ev = (mn[i] > 0);
            ed = ev ? mq[i][0] : 32'h0;
            check_eq($sformatf("i%0d.tvalid", i), 32'(tv[i]), 32'(ev));
            check_eq($sformatf("i%0d.tdata", i), td[i], ed);
            check_eq($sformatf("i%0d.tlast", i), 32'(tl[i]),
                     32'(ev && (msent[i] == ofm_tab[i] - 1)));
            check_eq($sformatf("i%0d.frame_done", i), 32'(fd[i]), 32'(mdone[i]));
            check_eq($sformatf("i%0d.overflow", i), 32'(ovf[i]), 32'(movf[i]));
            check_eq($sformatf("i%0d.fill", i), 32'(fill[i]), 32'(mn[i]));
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit r);
        in_valid = v; in_data = d; tready = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Asynchronous assert between edges, release on a falling edge
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        ofm_tab[0] = 49; ofm_tab[1] = 4; ofm_tab[2] = 1;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Basic frame
        for (int k = 0; k < 49; k++) cycle(1'b1, 32'(k), 1'b1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        check_eq("basic.overflow0", 32'(ovf[0]), 32'h0);
        apply_reset();

        // Backpressure: only the first 16 words survive
        for (int k = 0; k < 49; k++) cycle(1'b1, 32'h100 + 32'(k), 1'b0);
        check_eq("bp.fill0", 32'(fill[0]), 32'd16);
        check_eq("bp.overflow0", 32'(ovf[0]), 32'h1);
        repeat (20) cycle(1'b0, 32'h0, 1'b1);
        check_eq("bp.fill0_empty", 32'(fill[0]), 32'd0);
        apply_reset();

        // Full FIFO with simultaneous read and write
        for (int k = 0; k < 16; k++) cycle(1'b1, 32'h200 + 32'(k), 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h210 + 32'(k), 1'b1);
            check_eq("full_rw.fill0", 32'(fill[0]), 32'd16);
            check_eq("full_rw.overflow0", 32'(ovf[0]), 32'h0);
        end
        apply_reset();

        // Extra word while draining (frame size 4)
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'h300 + 32'(k), 1'b0);
        check_eq("drain.overflow1", 32'(ovf[1]), 32'h1);
        check_eq("drain.fill1", 32'(fill[1]), 32'd4);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        apply_reset();

        // Reset in the middle of a frame, then a clean frame
        for (int k = 0; k < 10; k++) cycle(1'b1, 32'h400 + 32'(k), 1'b0);
        check_eq("midrst.tvalid0_before", 32'(tv[0]), 32'h1);
        apply_reset();
        for (int k = 0; k < 49; k++) cycle(1'b1, 32'h500 + 32'(k), 1'b1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        apply_reset();

        // TLAST stability on the single-element frame
        cycle(1'b1, 32'hABCD_0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 32'h0, 1'b0);
            check_eq("hold.tvalid2", 32'(tv[2]), 32'h1);
            check_eq("hold.tlast2", 32'(tl[2]), 32'h1);
            check_eq("hold.tdata2", td[2], 32'hABCD_0001);
        end
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("hold.done2", 32'(fd[2]), 32'h1);
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("hold.done2_off", 32'(fd[2]), 32'h0);
        apply_reset();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0), $urandom(),
                      ($urandom_range(0, 9) < 6));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
